mpu_load_sequencer: RTL and testbench
=====================================

Name: mpu_load_sequencer

Overview:
- Upstream feeder for the MPU matrix register file load port.
- Accepts a load request (target register, M×N size), then consumes a stream of float_sp elements from memory, one per handshake.
- Generates row-major (i,j) coordinates and drives one register-file write strobe per element, honouring the register file's load-ready.
- Pulses done when the whole matrix has been written.

Parameters:
- M, 4, max matrix rows
- N, 4, max matrix columns
- MATRIX_REGISTERS, 8, number of matrix registers in the register file
- RBITS, $clog2(MATRIX_REGISTERS), register address width
- MW, $clog2(M+1), row index/size width
- NW, $clog2(N+1), column index/size width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid_in  in  1  load request valid
- req_ready_out  out  1  sequencer idle, request accepted this cycle if valid
- req_addr_in  in  RBITS  target matrix register
- req_m_in  in  MW  rows, 1..M
- req_n_in  in  NW  columns, 1..N
- mem_valid_in  in  1  memory element valid
- mem_ready_out  out  1  sequencer accepts element
- mem_element_in  in  32  float_sp element, row-major order
- reg_load_ready_in  in  1  register file load ready
- reg_load_en_out  out  1  register file write strobe
- reg_load_addr_out  out  RBITS  register address
- reg_i_load_loc_out  out  MW  row location
- reg_j_load_loc_out  out  NW  column location
- reg_m_load_size_out  out  MW  latched rows
- reg_n_load_size_out  out  NW  latched columns
- reg_load_element_out  out  32  element data
- busy_out  out  1  state != IDLE
- done_out  out  1  one-cycle completion pulse
- error_out  out  1  one-cycle illegal-size pulse

Behaviour:
- Reset and clock:
  - Reset rst, synchronous, active-high; clock clk.
  - On rst all outputs are 0, state is IDLE, counters are 0, and latched addr/size are 0.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - req_ready_out=1; mem_ready_out=0.
  - mem_valid_in is ignored.
  - On req_valid_in:
    - If m==0, n==0, m>M or n>N: error_out=1 next cycle, stay IDLE, nothing latched.
    - Otherwise latch addr/m/n, clear i=j=0, go to LOAD.
- LOAD:
  - req_ready_out=0; requests are held off.
  - mem_ready_out = reg_load_ready_in (combinational).
  - Transfer occurs when mem_valid_in && mem_ready_out.
  - On transfer, the next cycle drives reg_load_en_out=1 with the captured element, the current i/j, the latched addr and the latched sizes.
  - Counters advance row-major: j+1; when j==n-1, j=0 and i+1.
  - No transfer: reg_load_en_out=0 next cycle; counters hold.
  - Transfer at i==m-1, j==n-1: go to DONE.
- DONE (one cycle):
  - reg_load_en_out=1 for the final element and done_out=1 in the same cycle.
  - mem_ready_out=0.
  - Go to IDLE.
  - A new request can be accepted the cycle after DONE.
- Write-strobe timing:
  - Latency is exactly one cycle from element transfer to write strobe.
  - Throughput is 1 element/cycle while ready and valid stay high.
- Address/size outputs:
  - reg_load_addr_out and the size outputs hold their latched values until the next accepted request.
- reg_load_ready_in low:
  - mem_ready_out drops the same cycle.
  - No strobe follows an untransferred cycle.
  - No element is lost or duplicated.
- rst mid-LOAD: abort immediately, no done_out, and no strobe in the following cycle. Partial register contents are not cleaned up.
- 1×1 matrix: IDLE → LOAD → DONE; single strobe at (0,0).
- Count arithmetic is unsigned. i never exceeds m-1 and j never exceeds n-1.

Optional Feature:
- Macro: MPU_LOAD_TRANSPOSE_EN.
- With the macro:
  - Extra input req_transpose_in (1 bit), latched on request acceptance.
  - When the latched bit is 1, the fill is column-major: i+1 first; when i==m-1, i=0 and j+1. Last element is still (m-1,n-1).
  - Reported sizes are unchanged (m,n). The source stream is therefore the n×m source matrix, stored transposed.
- Without the macro: the port is absent and the fill is row-major only.

Test Plan:
- Basic load: req addr=3, m=2, n=3; six elements 1.0..6.0 streamed with ready and valid high → strobes at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with data 1.0..6.0 in order, addr=3, sizes 2/3; done_out pulses with the 6th strobe.
- Backpressure: same request, reg_load_ready_in low on cycles 2–4 of LOAD, mem_valid_in held high → mem_ready_out low in those cycles, no strobes for them, 6 strobes total, no duplicate.
- Illegal sizes: req m=0, n=2, then m=5, n=1 (M=4) → error_out pulses each time, busy_out stays 0, no strobes.
- Reset mid-load: m=4, n=4, rst asserted after 5 transfers → next cycle all outputs 0 and IDLE; no done_out; a new 1×1 request then completes normally.
- Back-to-back: 1×1 to addr 0 then 2×2 to addr 7, req_valid_in held → second request accepted the cycle after done_out; correct addr on each strobe.
- Transpose (MPU_LOAD_TRANSPOSE_EN): m=2, n=2, req_transpose_in=1, elements A,B,C,D → strobes (0,0)=A, (1,0)=B, (0,1)=C, (1,1)=D.

Source files
------------

// File: rtl/mpu_load_sequencer.sv
// Load sequencer feeding the MPU matrix register file from a memory element stream.
// Optional column-major (transposed) fill is enabled by defining MPU_LOAD_TRANSPOSE_EN.
module mpu_load_sequencer #(
  parameter int M                = 4,
  parameter int N                = 4,
  parameter int MATRIX_REGISTERS = 8,
  parameter int RBITS            = $clog2(MATRIX_REGISTERS),
  parameter int MW               = $clog2(M + 1),
  parameter int NW               = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic [RBITS-1:0] req_addr_in,
  input  logic [MW-1:0]    req_m_in,
  input  logic [NW-1:0]    req_n_in,
`ifdef MPU_LOAD_TRANSPOSE_EN
  input  logic             req_transpose_in,
`endif
  input  logic             mem_valid_in,
  output logic             mem_ready_out,
  input  logic [31:0]      mem_element_in,
  input  logic             reg_load_ready_in,
  output logic             reg_load_en_out,
  output logic [RBITS-1:0] reg_load_addr_out,
  output logic [MW-1:0]    reg_i_load_loc_out,
  output logic [NW-1:0]    reg_j_load_loc_out,
  output logic [MW-1:0]    reg_m_load_size_out,
  output logic [NW-1:0]    reg_n_load_size_out,
  output logic [31:0]      reg_load_element_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             error_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    i_q, i_next;
  logic [NW-1:0]    j_q, j_next;
  logic [RBITS-1:0] addr_q;
  logic [MW-1:0]    m_q;
  logic [NW-1:0]    n_q;
  logic             transpose_q;
  logic             en_q;
  logic [31:0]      element_q;
  logic [MW-1:0]    i_loc_q;
  logic [NW-1:0]    j_loc_q;
  logic             error_q;

  logic size_ok;
  logic req_fire;
  logic xfer;
  logic i_last;
  logic j_last;

  assign size_ok = (req_m_in != '0) && (req_n_in != '0) &&
                   (req_m_in <= MW'(M)) && (req_n_in <= NW'(N));

  // Handshake readies are masked by rst so nothing is accepted during an abort.
  assign req_ready_out = (state_q == IDLE) && !rst;
  assign mem_ready_out = (state_q == LOAD) && reg_load_ready_in && !rst;

  assign req_fire = req_valid_in && req_ready_out;
  assign xfer     = mem_valid_in && mem_ready_out;
  assign i_last   = (i_q == m_q - MW'(1));
  assign j_last   = (j_q == n_q - NW'(1));

`ifdef MPU_LOAD_TRANSPOSE_EN
  logic transpose_req;
  assign transpose_req = req_transpose_in;
`else
  logic transpose_req;
  assign transpose_req = 1'b0;
`endif

  // Coordinate walk: row-major by default, column-major when the latched transpose bit is set.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    i_next = i_q;
    j_next = j_q;
    if (i_last && j_last) begin
      i_next = '0;
      j_next = '0;
    end else if (transpose_q) begin
      if (i_last) begin
        i_next = '0;
        j_next = j_q + NW'(1);
      end else begin
        i_next = i_q + MW'(1);
      end
    end else begin
      if (j_last) begin
        j_next = '0;
        i_next = i_q + MW'(1);
      end else begin
        j_next = j_q + NW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_fire && size_ok) state_d = LOAD;
      LOAD:    if (xfer && i_last && j_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-high; all state uses non-blocking assignment.
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      addr_q      <= '0;
      m_q         <= '0;
      n_q         <= '0;
      transpose_q <= 1'b0;
      en_q        <= 1'b0;
      element_q   <= '0;
      i_loc_q     <= '0;
      j_loc_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= xfer;
      error_q <= req_fire && !size_ok;
      if (req_fire && size_ok) begin
        addr_q      <= req_addr_in;
        m_q         <= req_m_in;
        n_q         <= req_n_in;
        transpose_q <= transpose_req;
        i_q         <= '0;
        j_q         <= '0;
      end
      if (xfer) begin
        element_q <= mem_element_in;
        i_loc_q   <= i_q;
        j_loc_q   <= j_q;
        i_q       <= i_next;
        j_q       <= j_next;
      end
    end
  end

  assign reg_load_en_out      = en_q;
  assign reg_load_addr_out    = addr_q;
  assign reg_i_load_loc_out   = i_loc_q;
  assign reg_j_load_loc_out   = j_loc_q;
  assign reg_m_load_size_out  = m_q;
  assign reg_n_load_size_out  = n_q;
  assign reg_load_element_out = element_q;
  assign busy_out             = (state_q != IDLE);
  assign done_out             = (state_q == DONE);
  assign error_out            = error_q;

endmodule

// File: tb/tb_mpu_load_sequencer.sv
// Randomized self-checking bench for mpu_load_sequencer against a coordinate/stream model.
// Define MPU_LOAD_TRANSPOSE_EN to also exercise the transposed fill.
module tb_mpu_load_sequencer;

  localparam int RBITS = 3;
  localparam int MW    = 3;
  localparam int NW    = 3;

  logic             clk;
  logic             rst;
  logic             req_valid_in;
  logic             req_ready_out;
  logic [RBITS-1:0] req_addr_in;
  logic [MW-1:0]    req_m_in;
  logic [NW-1:0]    req_n_in;
`ifdef MPU_LOAD_TRANSPOSE_EN
  logic             req_transpose_in;
`endif
  logic             mem_valid_in;
  logic             mem_ready_out;
  logic [31:0]      mem_element_in;
  logic             reg_load_ready_in;
  logic             reg_load_en_out;
  logic [RBITS-1:0] reg_load_addr_out;
  logic [MW-1:0]    reg_i_load_loc_out;
  logic [NW-1:0]    reg_j_load_loc_out;
  logic [MW-1:0]    reg_m_load_size_out;
  logic [NW-1:0]    reg_n_load_size_out;
  logic [31:0]      reg_load_element_out;
  logic             busy_out;
  logic             done_out;
  logic             error_out;

  mpu_load_sequencer dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid_in         (req_valid_in),
    .req_ready_out        (req_ready_out),
    .req_addr_in          (req_addr_in),
    .req_m_in             (req_m_in),
    .req_n_in             (req_n_in),
`ifdef MPU_LOAD_TRANSPOSE_EN
    .req_transpose_in     (req_transpose_in),
`endif
    .mem_valid_in         (mem_valid_in),
    .mem_ready_out        (mem_ready_out),
    .mem_element_in       (mem_element_in),
    .reg_load_ready_in    (reg_load_ready_in),
    .reg_load_en_out      (reg_load_en_out),
    .reg_load_addr_out    (reg_load_addr_out),
    .reg_i_load_loc_out   (reg_i_load_loc_out),
    .reg_j_load_loc_out   (reg_j_load_loc_out),
    .reg_m_load_size_out  (reg_m_load_size_out),
    .reg_n_load_size_out  (reg_n_load_size_out),
    .reg_load_element_out (reg_load_element_out),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .error_out            (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: element stream to send and the last accepted request.
  logic [31:0] src [$];
  int last_addr = 0;
  int last_m    = 0;
  int last_n    = 0;
  int nxt_addr  = 0;
  int nxt_m     = 1;
  int nxt_n     = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready_out, 0);
    check({tag, "_mem_ready"}, mem_ready_out, 0);
    check({tag, "_en"},        reg_load_en_out, 0);
    check({tag, "_addr"},      reg_load_addr_out, 0);
    check({tag, "_i"},         reg_i_load_loc_out, 0);
    check({tag, "_j"},         reg_j_load_loc_out, 0);
    check({tag, "_m"},         reg_m_load_size_out, 0);
    check({tag, "_n"},         reg_n_load_size_out, 0);
    check({tag, "_elem"},      reg_load_element_out, 0);
    check({tag, "_busy"},      busy_out, 0);
    check({tag, "_done"},      done_out, 0);
    check({tag, "_error"},     error_out, 0);
  endtask

  task automatic fill_src(input int total, input bit floats);
    // 1.0 .. 6.0 in IEEE-754 single precision, then random words
    logic [31:0] f [6];
    f = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000, 32'h40c00000};
    src.delete();
    for (int k = 0; k < total; k++) src.push_back((floats && k < 6) ? f[k] : $urandom());
  endtask

  // One full load: accept the request, stream the elements, check every strobe against the model.
  task automatic run_load(input int addr, input int m, input int n, input bit tr,
                          input int vprob, input int rprob, input logic [31:0] low_mask,
                          input int abort_after, input bit chain);
    int  total, sent, seen, cyc;
    int  ei, ej;
    bit  pend, fin, eff_tr;
    total = m * n; sent = 0; seen = 0; cyc = 0; pend = 0; fin = 0;
`ifdef MPU_LOAD_TRANSPOSE_EN
    eff_tr = tr;
    req_transpose_in = tr;
`else
    eff_tr = 1'b0;
`endif
    req_valid_in      = 1'b1;
    req_addr_in       = RBITS'(addr);
    req_m_in          = MW'(m);
    req_n_in          = NW'(n);
    mem_valid_in      = 1'b1;
    mem_element_in    = 32'hdeadbeef;
    reg_load_ready_in = 1'b1;
    @(negedge clk);
    check("accept_ready", req_ready_out, 1);
    check("idle_mem_ready", mem_ready_out, 0);
    check("idle_busy", busy_out, 0);
    check("idle_strobe", reg_load_en_out, 0);
    check("idle_done", done_out, 0);
    check("addr_hold", reg_load_addr_out, last_addr);
    check("m_hold", reg_m_load_size_out, last_m);
    check("n_hold", reg_n_load_size_out, last_n);
    last_addr = addr; last_m = m; last_n = n;
    @(posedge clk); #1;
    while (!fin) begin
      bit lr, mv, rst_now;
      rst_now = (abort_after > 0) && (sent == abort_after);
      if (chain) begin
        req_addr_in = RBITS'(nxt_addr);
        req_m_in    = MW'(nxt_m);
        req_n_in    = NW'(nxt_n);
      end else begin
        req_valid_in = 1'b0;
      end
      lr = !(cyc < 32 && low_mask[cyc]) && ($urandom_range(99) < rprob);
      mv = (sent < total) && !rst_now && ($urandom_range(99) < vprob);
      reg_load_ready_in = lr;
      mem_valid_in      = mv;
      mem_element_in    = mv ? src[sent] : $urandom();
      rst               = rst_now;
      @(negedge clk);
      check("mem_ready", mem_ready_out, (sent < total) && lr && !rst_now);
      check("req_ready_busy", req_ready_out, 0);
      check("busy", busy_out, 1);
      check("error_quiet", error_out, 0);
      check("strobe", reg_load_en_out, pend);
      if (pend && reg_load_en_out) begin
        ei = eff_tr ? (seen % m) : (seen / n);
        ej = eff_tr ? (seen / m) : (seen % n);
        check("strobe_i", reg_i_load_loc_out, ei);
        check("strobe_j", reg_j_load_loc_out, ej);
        check("strobe_elem", reg_load_element_out, src[seen]);
        check("strobe_addr", reg_load_addr_out, addr);
        check("strobe_m", reg_m_load_size_out, m);
        check("strobe_n", reg_n_load_size_out, n);
        check("done", done_out, seen == total - 1);
      end else begin
        check("done_quiet", done_out, 0);
      end
      if (pend) seen++;
      pend = mv && lr;
      if (pend) sent++;
      cyc++;
      @(posedge clk); #1;
      if (rst_now) begin
        @(negedge clk);
        check_all_zero("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        last_addr = 0; last_m = 0; last_n = 0;
        fin = 1'b1;
      end else if (seen == total) begin
        fin = 1'b1;
      end else if (cyc > 2000) begin
        check("load_timeout", seen, total);
        fin = 1'b1;
      end
    end
    if (!chain) req_valid_in = 1'b0;
    mem_valid_in = 1'b0;
  endtask

  task automatic bad_req(input int m, input int n);
    req_valid_in      = 1'b1;
    req_addr_in       = RBITS'($urandom());
    req_m_in          = MW'(m);
    req_n_in          = NW'(n);
    mem_valid_in      = 1'b1;
    reg_load_ready_in = 1'b1;
    @(negedge clk);
    check("bad_ready", req_ready_out, 1);
    check("bad_idle_err", error_out, 0);
    @(posedge clk); #1;
    req_valid_in = 1'b0;
    mem_valid_in = 1'b0;
    @(negedge clk);
    check("error_pulse", error_out, 1);
    check("bad_busy", busy_out, 0);
    check("bad_strobe", reg_load_en_out, 0);
    check("bad_addr_hold", reg_load_addr_out, last_addr);
    check("bad_m_hold", reg_m_load_size_out, last_m);
    check("bad_n_hold", reg_n_load_size_out, last_n);
    @(posedge clk); #1;
    @(negedge clk);
    check("error_one_cycle", error_out, 0);
    check("bad_busy_after", busy_out, 0);
    check("bad_strobe_after", reg_load_en_out, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst               = 1'b1;
    req_valid_in      = 1'b0;
    req_addr_in       = '0;
    req_m_in          = '0;
    req_n_in          = '0;
`ifdef MPU_LOAD_TRANSPOSE_EN
    req_transpose_in  = 1'b0;
`endif
    mem_valid_in      = 1'b0;
    mem_element_in    = '0;
    reg_load_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic 2x3 load, full throughput
    fill_src(6, 1'b1);
    run_load(3, 2, 3, 1'b0, 100, 100, 32'h0, 0, 1'b0);

    // Backpressure on LOAD cycles 2..4
    fill_src(6, 1'b1);
    run_load(3, 2, 3, 1'b0, 100, 100, 32'h0000_000e, 0, 1'b0);

    // Illegal sizes
    bad_req(0, 2);
    bad_req(5, 1);
    bad_req(2, 0);
    bad_req(1, 5);

    // Abort a 4x4 load after five transfers, then a 1x1 completes
    fill_src(16, 1'b0);
    run_load(5, 4, 4, 1'b0, 100, 100, 32'h0, 5, 1'b0);
    fill_src(1, 1'b0);
    run_load(2, 1, 1, 1'b0, 100, 100, 32'h0, 0, 1'b0);

    // Back-to-back with req_valid held
    fill_src(4, 1'b0);
    nxt_addr = 7; nxt_m = 2; nxt_n = 2;
    run_load(0, 1, 1, 1'b0, 100, 100, 32'h0, 0, 1'b1);
    run_load(7, 2, 2, 1'b0, 100, 100, 32'h0, 0, 1'b0);

`ifdef MPU_LOAD_TRANSPOSE_EN
    fill_src(4, 1'b0);
    run_load(1, 2, 2, 1'b1, 100, 100, 32'h0, 0, 1'b0);
    fill_src(12, 1'b0);
    run_load(4, 3, 4, 1'b1, 70, 70, 32'h0, 0, 1'b0);
`endif

    // Randomized loads with random valid/ready gaps and occasional illegal requests
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(5) == 0) begin
        if ($urandom_range(1) == 0) bad_req(0, $urandom_range(4));
        else                        bad_req($urandom_range(5, 7), $urandom_range(1, 4));
      end else begin
        int m, n;
        m = $urandom_range(1, 4);
        n = $urandom_range(1, 4);
        fill_src(m * n, 1'b0);
        run_load($urandom_range(7), m, n, 1'($urandom_range(1)),
                 $urandom_range(30, 100), $urandom_range(30, 100), 32'h0, 0, 1'b0);
      end
    end

    @(negedge clk);
    check("final_idle_busy", busy_out, 0);
    check("final_idle_ready", req_ready_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
